// File: rtl/ir_bus_pkg.sv
// Shared types and constants for the instruction/data bus writer.
package ir_bus_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bus_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ir_bus_fifo.sv
// Small synchronous FIFO with occupancy count and registered ready flag.
// Pointers and count reset asynchronously; the data array is not reset.
module ir_bus_fifo
    import ir_bus_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             ready_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Head is read straight from the array; the writer's output register
    // provides the registered stage when the word is popped.
    assign rd_data = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            ready_reg <= (count_next != FULL);
        end
    end

    assign count = count_reg;
    assign ready = ready_reg;

endmodule

// File: rtl/ir_bus_writer.sv
// Bus-master writer: buffers upstream words, arbitrates, and drives each word
// with a setup/strobe/hold busEn sequence. Optional IR_BUS_WRITER_PARITY_EN adds busParity.
module ir_bus_writer
    import ir_bus_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int DEPTH         = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           inData,
    input  logic                       inValid,
    output logic                       inReady,
    output logic                       busReq,
    input  logic                       busGrant,
    output logic [WIDTH-1:0]           bus,
    output logic                       busOe,
    output logic                       busEn,
`ifdef IR_BUS_WRITER_PARITY_EN
    output logic                       busParity,
`endif
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW     = $clog2(DEPTH+1);
    localparam int PH_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int PW     = $clog2(PH_MAX+1);

    localparam logic [PW-1:0] SETUP_LAST  = PW'(SETUP_CYCLES-1);
    localparam logic [PW-1:0] STROBE_LAST = PW'(STROBE_CYCLES-1);
    localparam logic [PW-1:0] HOLD_LAST   = PW'(HOLD_CYCLES-1);
    localparam logic [PW-1:0] PH_TERM     = PW'(PH_MAX);

    bus_state_e       state_reg;
    bus_state_e       state_next;
    logic [PW-1:0]    phase_reg;
    logic [PW-1:0]    phase_next;
    logic             bus_req_reg;
    logic             bus_req_next;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_ready;
    logic             push;
    logic             pop;

    assign push = inValid & fifo_ready;

    ir_bus_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (push),
        .wr_data (inData),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .ready   (fifo_ready)
    );

    always_comb begin
        state_next = state_reg;
        phase_next = (phase_reg == PH_TERM) ? phase_reg : phase_reg + PW'(1);
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                phase_next = '0;
                if (bus_req_reg && busGrant && (fifo_count != '0)) begin
                    state_next = SETUP;
                    pop        = 1'b1;
                end
            end
            SETUP: begin
                if (phase_reg == SETUP_LAST) begin
                    state_next = STROBE;
                    phase_next = '0;
                end
            end
            STROBE: begin
                if (phase_reg == STROBE_LAST) begin
                    state_next = HOLD;
                    phase_next = '0;
                end
            end
            HOLD: begin
                if (phase_reg == HOLD_LAST) begin
                    phase_next = '0;
                    // Grant is only consulted at word boundaries; a drop
                    // mid-transfer never cuts a word short.
                    if ((fifo_count != '0) && busGrant) begin
                        state_next = SETUP;
                        pop        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase
        // Uses the pre-edge count so a fresh push shows up on busReq one
        // cycle later, keeping busReq purely registered.
        bus_req_next = (state_next != IDLE) || (fifo_count != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            phase_reg   <= '0;
            bus_req_reg <= 1'b0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            bus_req_reg <= bus_req_next;
            if (pop) begin
                data_reg <= head;
            end
        end
    end

`ifdef IR_BUS_WRITER_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_reg <= 1'b0;
        end else if (pop) begin
            parity_reg <= ^head;
        end
    end

    assign busParity = busOe & parity_reg;
`endif

    assign busOe   = (state_reg != IDLE);
    assign busEn   = (state_reg == STROBE);
    assign bus     = {WIDTH{busOe}} & data_reg;
    assign busReq  = bus_req_reg;
    assign busy    = (state_reg != IDLE) || (fifo_count != '0);
    assign inReady = fifo_ready;
    assign count   = fifo_count;

endmodule

// File: tb/tb_ir_bus_writer.sv
// Directed self-checking bench for ir_bus_writer (default and swept timing).
module tb_ir_bus_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        bus_req;
    logic        bus_grant;
    logic [15:0] bus;
    logic        bus_oe;
    logic        bus_en;
    logic        busy;
    logic [2:0]  count;
`ifdef IR_BUS_WRITER_PARITY_EN
    logic        bus_parity;
    logic        s_parity;
`endif

    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_req;
    logic        s_grant;
    logic [15:0] s_bus;
    logic        s_oe;
    logic        s_en;
    logic        s_busy;
    logic [2:0]  s_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ir_bus_writer dut (
        .clk       (clk),
        .reset     (rst_n),
        .inData    (in_data),
        .inValid   (in_valid),
        .inReady   (in_ready),
        .busReq    (bus_req),
        .busGrant  (bus_grant),
        .bus       (bus),
        .busOe     (bus_oe),
        .busEn     (bus_en),
`ifdef IR_BUS_WRITER_PARITY_EN
        .busParity (bus_parity),
`endif
        .busy      (busy),
        .count     (count)
    );

    ir_bus_writer #(
        .SETUP_CYCLES  (2),
        .STROBE_CYCLES (3),
        .HOLD_CYCLES   (2)
    ) dut2 (
        .clk       (clk),
        .reset     (rst_n),
        .inData    (s_data),
        .inValid   (s_valid),
        .inReady   (s_ready),
        .busReq    (s_req),
        .busGrant  (s_grant),
        .bus       (s_bus),
        .busOe     (s_oe),
        .busEn     (s_en),
`ifdef IR_BUS_WRITER_PARITY_EN
        .busParity (s_parity),
`endif
        .busy      (s_busy),
        .count     (s_count)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus_req, bus_oe, bus_en, bus, busy, count, in_ready} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs: req=%b oe=%b en=%b bus=%h busy=%b count=%0d ready=%b, required all 0",
                     bus_req, bus_oe, bus_en, bus, busy, count, in_ready);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({in_ready, count} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL reset_release: ready=%b count=%0d, required ready=1 count=0", in_ready, count);
        end
        $display("reset: released, ready=%b count=%0d", in_ready, count);
    endtask

    task automatic test_single;
        logic [0:5] er;
        logic [0:5] eo;
        logic [0:5] ee;
        logic [15:0] eb;
        er = 6'b011110;
        eo = 6'b001110;
        ee = 6'b000100;
        bus_grant = 1'b1;
        in_data   = 16'hA5C3;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            eb = eo[i] ? 16'hA5C3 : 16'h0000;
            n_cmp++;
            if ({bus_req, bus_oe, bus_en, bus} !== {er[i], eo[i], ee[i], eb}) begin
                n_err++;
                $display("FAIL single_c%0d: req/oe/en/bus=%b%b%b/%h, required %b%b%b/%h",
                         i, bus_req, bus_oe, bus_en, bus, er[i], eo[i], ee[i], eb);
            end
        end
        $display("single: word A5C3 sent");
    endtask

    task automatic test_fill_drain;
        logic [15:0] w [5];
        logic [2:0]  ce;
        logic        re;
        w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        bus_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data  = w[i];
            in_valid = 1'b1;
            step();
            ce = (i < 4) ? 3'(i + 1) : 3'd4;
            re = (i < 3);
            n_cmp++;
            if ({count, in_ready} !== {ce, re}) begin
                n_err++;
                $display("FAIL fill_p%0d: count=%0d ready=%b, required count=%0d ready=%b",
                         i, count, in_ready, ce, re);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if ({bus_req, bus_oe, count} !== {1'b1, 1'b0, 3'd4}) begin
            n_err++;
            $display("FAIL fill_wait: req=%b oe=%b count=%0d, required req=1 oe=0 count=4",
                     bus_req, bus_oe, count);
        end
        bus_grant = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            n_cmp++;
            if ({bus_req, bus_oe, bus_en} !== {1'b1, 1'b1, (c % 3) == 1}) begin
                n_err++;
                $display("FAIL drain_c%0d: req/oe/en=%b%b%b, required 11%b",
                         c, bus_req, bus_oe, bus_en, (c % 3) == 1);
            end
            n_cmp++;
            if (bus !== w[c / 3]) begin
                n_err++;
                $display("FAIL drain_bus_c%0d: bus=%h, required %h", c, bus, w[c / 3]);
            end
        end
        step();
        n_cmp++;
        if ({bus_req, bus_oe, busy, count} !== 6'd0) begin
            n_err++;
            $display("FAIL drain_end: req=%b oe=%b busy=%b count=%0d, required all 0",
                     bus_req, bus_oe, busy, count);
        end
        $display("fill_drain: 4 words drained");
    endtask

    task automatic test_grant_drop;
        logic [0:3] eo;
        logic [0:3] ee;
        logic [15:0] eb;
        eo = 4'b1110;
        ee = 4'b0100;
        bus_grant = 1'b0;
        in_data   = 16'h1234;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({bus_req, bus_oe, busy} !== 3'b101) begin
                n_err++;
                $display("FAIL withheld_c%0d: req=%b oe=%b busy=%b, required req=1 oe=0 busy=1",
                         i, bus_req, bus_oe, busy);
            end
        end
        bus_grant = 1'b1;
        step();
        bus_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            eb = eo[i] ? 16'h1234 : 16'h0000;
            n_cmp++;
            if ({bus_oe, bus_en, bus} !== {eo[i], ee[i], eb}) begin
                n_err++;
                $display("FAIL dropped_c%0d: oe/en/bus=%b%b/%h, required %b%b/%h",
                         i, bus_oe, bus_en, bus, eo[i], ee[i], eb);
            end
        end
        $display("grant_drop: word 1234 completed");
    endtask

    task automatic test_reset_mid_strobe;
        bit seen;
        seen = 1'b0;
        bus_grant = 1'b1;
        in_data   = 16'hBEEF;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bus_en;
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_err++;
            $display("FAIL strobe_wait: busEn seen=%b, required 1 within 10 cycles", seen);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus_req, bus_oe, bus_en, bus, busy, count, in_ready} !== 23'd0) begin
            n_err++;
            $display("FAIL async_reset: req=%b oe=%b en=%b bus=%h busy=%b count=%0d ready=%b, required all 0",
                     bus_req, bus_oe, bus_en, bus, busy, count, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({in_ready, count} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL reset_rerelease: ready=%b count=%0d, required ready=1 count=0", in_ready, count);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({bus_req, bus_oe} !== 2'b00) begin
                n_err++;
                $display("FAIL no_retransmit_c%0d: req=%b oe=%b, required 0 0", i, bus_req, bus_oe);
            end
        end
        bus_grant = 1'b0;
        $display("reset_mid_strobe: word BEEF aborted");
    endtask

    task automatic test_sweep;
        int oe_cnt;
        int en_cnt;
        int oe_first;
        int en_first;
        oe_cnt   = 0;
        en_cnt   = 0;
        oe_first = -1;
        en_first = -1;
        s_grant = 1'b1;
        s_data  = 16'hC0DE;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_oe) begin
                oe_cnt++;
                if (oe_first < 0) oe_first = i;
                n_cmp++;
                if (s_bus !== 16'hC0DE) begin
                    n_err++;
                    $display("FAIL sweep_bus_c%0d: bus=%h, required c0de", i, s_bus);
                end
            end
            if (s_en) begin
                en_cnt++;
                if (en_first < 0) en_first = i;
            end
        end
        n_cmp++;
        if (oe_cnt != 7 || en_cnt != 3 || (en_first - oe_first) != 2) begin
            n_err++;
            $display("FAIL sweep_timing: oe_cycles=%0d en_cycles=%0d en_offset=%0d, required 7 3 2",
                     oe_cnt, en_cnt, en_first - oe_first);
        end
        s_grant = 1'b0;
        $display("sweep: oe=%0d en=%0d offset=%0d", oe_cnt, en_cnt, en_first - oe_first);
    endtask

`ifdef IR_BUS_WRITER_PARITY_EN
    task automatic test_parity_word(input logic [15:0] word, input logic exp_par);
        bit seen;
        seen = 1'b0;
        bus_grant = 1'b1;
        in_data   = word;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bus_oe;
            if (!bus_oe) begin
                n_cmp++;
                if (bus_parity !== 1'b0) begin
                    n_err++;
                    $display("FAIL parity_idle_%h: busParity=%b, required 0", word, bus_parity);
                end
            end
        end
        n_cmp++;
        if (seen !== 1'b1 || bus_parity !== exp_par) begin
            n_err++;
            $display("FAIL parity_%h: oe=%b busParity=%b, required oe=1 busParity=%b",
                     word, seen, bus_parity, exp_par);
        end
        repeat (3) step();
        n_cmp++;
        if ({bus_oe, bus_parity} !== 2'b00) begin
            n_err++;
            $display("FAIL parity_after_%h: oe=%b busParity=%b, required 0 0", word, bus_oe, bus_parity);
        end
        bus_grant = 1'b0;
        $display("parity: word %h busParity=%b", word, exp_par);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        bus_grant = 1'b0;
        s_data    = '0;
        s_valid   = 1'b0;
        s_grant   = 1'b0;
        test_reset();
        test_single();
        test_fill_drain();
        test_grant_drop();
        test_reset_mid_strobe();
        test_sweep();
`ifdef IR_BUS_WRITER_PARITY_EN
        test_parity_word(16'h0001, 1'b1);
        test_parity_word(16'h0003, 1'b0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
